mem_access_unit: RTL and testbench

//   Initiator side of the data memory port. Takes load/store requests from the

---
 rtl/mem_access_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, single-port data memory.
// Handles sub-word extension on loads and read-modify-write for byte/halfword stores.
module mem_access_unit #(
    parameter int unsigned ADDR_W    = 21,
    parameter int unsigned MEM_WORDS = 101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLw  = 3'b010;
    localparam logic [2:0] OpSb  = 3'b011;
    localparam logic [2:0] OpLbu = 3'b100;
    localparam logic [2:0] OpLhu = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;
    localparam logic [2:0] OpSw  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [1:0]          off_q, off_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;

    logic                req_byte, req_half, req_store, req_misal, req_oor;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_val;
    logic [31:0]         merge;

    // Request decode, evaluated on the incoming (not yet latched) request
    always_comb begin
        req_byte  = req_op inside {OpLb, OpSb, OpLbu};
        req_half  = req_op inside {OpLh, OpLhu, OpSh};
        req_store = req_op inside {OpSb, OpSh, OpSw};
        req_misal = (req_half && req_addr[0]) ||
                    (!req_byte && !req_half && (req_addr[1:0] != 2'b00));
        req_oor   = 32'(req_addr[ADDR_W+1:2]) >= MEM_WORDS;
    end

    // Lane selection and extension for loads
    always_comb begin
        unique case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (op_q)
            OpLb:    load_val = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   load_val = {24'h0, byte_sel};
            OpLh:    load_val = {{16{half_sel[15]}}, half_sel};
            OpLhu:   load_val = {16'h0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane
    always_comb begin
        merge = mem_rdata;
        if (op_q == OpSb) begin
            unique case (off_q)
                2'd0:    merge[7:0]   = wdata_q[7:0];
                2'd1:    merge[15:8]  = wdata_q[7:0];
                2'd2:    merge[23:16] = wdata_q[7:0];
                default: merge[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge[31:16] = wdata_q;
        end else begin
            merge[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d         = req_op;
                    off_d        = req_addr[1:0];
                    wdata_d      = req_wdata[15:0];
                    mem_addr_d   = req_addr[ADDR_W+1:2];
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    if (req_misal || req_oor) begin
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = StResp;
                    end else if (!req_store) begin
                        state_d = StLoad;
                    end else if (req_op == OpSw) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                        state_d     = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                resp_rdata_d = load_val;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StStore: begin
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StRmwRd: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = merge;
                state_d     = StRmwWr;
            end
            StRmwWr: begin
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= OpLw;
            off_q        <= 2'b00;
            wdata_q      <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = rst_n && (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifndef SYNTHESIS
    a_we_only_in_write_states : assert property (@(posedge clk) disable iff (!rst_n)
        mem_we |-> (state_q inside {StStore, StRmwWr}));
    a_resp_held : assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata)));
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus backpressure and reset-abort sequences.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W    = 21;
    localparam int unsigned MEM_WORDS = 101;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = 3'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [MEM_WORDS];
    logic        mem_init_done = 1'b0;
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    mem_access_unit #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = 32'h0;
        if (int'(mem_addr) < int'(MEM_WORDS)) mem_rdata = mem[int'(mem_addr)];
    end

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= 32'h0;
            mem[8] <= 32'h8765_4321;
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            if (int'(mem_addr) < int'(MEM_WORDS)) mem[int'(mem_addr)] <= mem_wdata;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic run_req(input logic [2:0] op, input logic [22:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int we);
        int guard;
        int w0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready before request", 32'(req_ready), 32'd1);
        w0        = we_cnt;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata      = resp_rdata;
        err        = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        we = we_cnt - w0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          wc;
        int          guard;

        vecs[0]  = '{OP_SW,  23'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1};
        vecs[1]  = '{OP_LW,  23'h10,  32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0};
        vecs[2]  = '{OP_LB,  23'h13,  32'h0,         32'hFFFF_FFDE, 1'b0, 2, 0};
        vecs[3]  = '{OP_LBU, 23'h13,  32'h0,         32'h0000_00DE, 1'b0, 2, 0};
        vecs[4]  = '{OP_LH,  23'h12,  32'h0,         32'hFFFF_DEAD, 1'b0, 2, 0};
        vecs[5]  = '{OP_LHU, 23'h10,  32'h0,         32'h0000_BEEF, 1'b0, 2, 0};
        vecs[6]  = '{OP_SB,  23'h11,  32'hFFFF_FF55, 32'h0,         1'b0, 3, 1};
        vecs[7]  = '{OP_LW,  23'h10,  32'h0,         32'hDEAD_55EF, 1'b0, 2, 0};
        vecs[8]  = '{OP_SH,  23'h12,  32'hABCD_1234, 32'h0,         1'b0, 3, 1};
        vecs[9]  = '{OP_LW,  23'h10,  32'h0,         32'h1234_55EF, 1'b0, 2, 0};
        vecs[10] = '{OP_LW,  23'h12,  32'h0,         32'h0,         1'b1, 1, 0};
        vecs[11] = '{OP_SH,  23'h11,  32'hFFFF_FFFF, 32'h0,         1'b1, 1, 0};
        vecs[12] = '{OP_LW,  23'h194, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[13] = '{OP_SW,  23'h190, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 1};
        vecs[14] = '{OP_LW,  23'h190, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 0};
        vecs[15] = '{OP_LB,  23'h191, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 0};
        vecs[16] = '{OP_LHU, 23'h192, 32'h0,         32'h0000_CAFE, 1'b0, 2, 0};
        vecs[17] = '{OP_SB,  23'h194, 32'h0000_0011, 32'h0,         1'b1, 1, 0};
        vecs[18] = '{OP_LBU, 23'h21,  32'h0,         32'h0000_0043, 1'b0, 2, 0};
        vecs[19] = '{OP_LH,  23'h22,  32'h0,         32'hFFFF_8765, 1'b0, 2, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready after reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lt, wc);
            check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].err));
            check($sformatf("v%0d latency", i), 32'(lt), 32'(vecs[i].lat));
            check($sformatf("v%0d mem_we count", i), 32'(wc), 32'(vecs[i].we));
        end

        // Backpressure: response held, competing request ignored until after handshake
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 23'h10;
        @(posedge clk); #1;
        req_addr = 23'h190;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d resp_valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("hold%0d rdata", i), resp_rdata, 32'h1234_55EF);
            check($sformatf("hold%0d req_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("hold%0d mem_addr", i), 32'(mem_addr), 32'd4);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        check("handshake cycle req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("after handshake resp_valid", 32'(resp_valid), 32'd0);
        check("after handshake req_ready", 32'(req_ready), 32'd1);
        check("after handshake mem_addr", 32'(mem_addr), 32'd4);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("queued req accepted", 32'(req_ready), 32'd0);
        check("queued req mem_addr", 32'(mem_addr), 32'd100);
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("queued req rdata", resp_rdata, 32'hCAFE_F00D);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset during RMW_RD of SB 0x20 must abort without a write
        wc        = we_cnt;
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 23'h20;
        req_wdata = 32'h0000_00A5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_rd mem_addr", 32'(mem_addr), 32'd8);
        rst_n = 1'b0;
        #1;
        check("abort resp_valid", 32'(resp_valid), 32'd0);
        check("abort mem_we", 32'(mem_we), 32'd0);
        check("abort mem_addr", 32'(mem_addr), 32'h0);
        check("abort mem_wdata", mem_wdata, 32'h0);
        check("abort req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort no write pulse", 32'(we_cnt - wc), 32'd0);
        check("abort word 8 intact", mem[8], 32'h8765_4321);
        @(posedge clk); #1;
        check("post-abort req_ready", 32'(req_ready), 32'd1);
        run_req(OP_LW, 23'h20, 32'h0, rd, er, lt, wc);
        check("post-abort LW rdata", rd, 32'h8765_4321);
        check("post-abort LW err", 32'(er), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
